// File: rtl/jb_car_seq_pkg.sv
// Shared types for the carrier enable/bandwidth sequencer.
// Holds the bandwidth encoding used toward the carrier clock-enable
// generator and the sequencer state encoding.
package jb_car_seq_pkg;

  // Bandwidth code presented on car_bw / bw_active.
  typedef logic [1:0] bw_t;

  localparam bw_t BW_20MHZ = 2'b00;
  localparam bw_t BW_10MHZ = 2'b01;
  localparam bw_t BW_5MHZ  = 2'b10;
  localparam bw_t BW_15MHZ = 2'b11;

  // Width of the shared dwell counter.
  localparam int unsigned CNT_W = 16;

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_ARM        = 3'd1,
    ST_ON_MIN     = 3'd2,
    ST_ON         = 3'd3,
    ST_ACK_WAIT   = 3'd4,
    ST_FLUSH_WAIT = 3'd5,
    ST_GUARD      = 3'd6
  } state_t;

  // IDLE and ON are the two resting states; everything else is a sequence.
  function automatic logic is_rest_state(state_t s);
    return (s == ST_IDLE) || (s == ST_ON);
  endfunction

endpackage

// File: rtl/jb_car_seq_if.sv
// Request/status bundle between register logic, the carrier sequencer
// and the carrier clock-enable generator.
// Optional macro JB_CAR_SEQ_FLUSH_TIMEOUT_EN adds the flush_timeout flag.
interface jb_car_seq_if;
  import jb_car_seq_pkg::*;

  logic cfg_car_en;
  bw_t  cfg_car_bw;
  logic dfe_flush;
  logic sticky_clr;
  logic car_en;
  bw_t  car_bw;
  logic busy;
  logic active;
  bw_t  bw_active;
  logic seq_done;
  logic ack_missing;
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
  logic flush_timeout;
`endif

  // Register/generator side: drives requests and flush status.
  modport master (
    output cfg_car_en, cfg_car_bw, dfe_flush, sticky_clr,
    input  car_en, car_bw, busy, active, bw_active, seq_done, ack_missing
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    , input flush_timeout
`endif
  );

  // Sequencer side.
  modport slave (
    input  cfg_car_en, cfg_car_bw, dfe_flush, sticky_clr,
    output car_en, car_bw, busy, active, bw_active, seq_done, ack_missing
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    , output flush_timeout
`endif
  );

endinterface

// File: rtl/jb_car_seq.sv
// Carrier enable/bandwidth sequencer, upstream of the carrier
// clock-enable generator. Holds car_bw stable ahead of every car_en rise,
// enforces a minimum on-time and runs bandwidth changes on a live carrier
// as disable -> flush -> guard -> re-enable, closed on dfe_flush.
// Optional macro JB_CAR_SEQ_FLUSH_TIMEOUT_EN: bounds FLUSH_WAIT and
// reports a sticky flush_timeout flag.
module jb_car_seq
  import jb_car_seq_pkg::*;
#(
  parameter bw_t         DEFAULT_BW           = BW_20MHZ,
  parameter int unsigned SETUP_CYCLES         = 4,
  parameter int unsigned MIN_ON_CYCLES        = 32,
  parameter int unsigned ACK_WAIT_CYCLES      = 16,
  parameter int unsigned GUARD_CYCLES         = 8
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
  , parameter int unsigned FLUSH_TIMEOUT_CYCLES = 8192
`endif
) (
  input  logic            clk,
  input  logic            resetn,
  jb_car_seq_if.slave     bus
);

  // Counter value on the last cycle of each timed state.
  localparam logic [CNT_W-1:0] SETUP_LAST  = CNT_W'(SETUP_CYCLES - 1);
  localparam logic [CNT_W-1:0] MIN_ON_LAST = CNT_W'(MIN_ON_CYCLES - 1);
  localparam logic [CNT_W-1:0] ACK_LAST    = CNT_W'(ACK_WAIT_CYCLES - 1);
  localparam logic [CNT_W-1:0] GUARD_LAST  = CNT_W'(GUARD_CYCLES - 1);
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
  localparam logic [CNT_W-1:0] FTO_LAST    = CNT_W'(FLUSH_TIMEOUT_CYCLES - 1);
`endif

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             car_en_q, car_en_d;
  bw_t              car_bw_q, car_bw_d;
  bw_t              bw_active_q, bw_active_d;
  logic             busy_q, active_q, seq_done_q;
  logic             ack_missing_q, ack_set;
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
  logic             flush_timeout_q, fto_set;
`endif

  // Next-state and next-output decode for the sequencer.
  always_comb begin
    state_d     = state_q;
    car_en_d    = car_en_q;
    car_bw_d    = car_bw_q;
    bw_active_d = bw_active_q;
    ack_set     = 1'b0;
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    fto_set     = 1'b0;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.cfg_car_en) begin
          car_bw_d = bus.cfg_car_bw;
          state_d  = ST_ARM;
        end
      end
      ST_ARM: begin
        // A dropped request wins over setup completion: car_en never rises.
        if (!bus.cfg_car_en) begin
          state_d = ST_IDLE;
        end else if (cnt_q == SETUP_LAST) begin
          car_en_d    = 1'b1;
          bw_active_d = car_bw_q;
          state_d     = ST_ON_MIN;
        end
      end
      ST_ON_MIN: begin
        if (cnt_q == MIN_ON_LAST) begin
          state_d = ST_ON;
        end
      end
      ST_ON: begin
        if (!bus.cfg_car_en || (bus.cfg_car_bw != car_bw_q)) begin
          car_en_d = 1'b0;
          state_d  = ST_ACK_WAIT;
        end
      end
      ST_ACK_WAIT: begin
        if (bus.dfe_flush) begin
          state_d = ST_FLUSH_WAIT;
        end else if (cnt_q == ACK_LAST) begin
          ack_set = 1'b1;
          state_d = ST_GUARD;
        end
      end
      ST_FLUSH_WAIT: begin
        if (!bus.dfe_flush) begin
          state_d = ST_GUARD;
        end
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
        else if (cnt_q == FTO_LAST) begin
          fto_set = 1'b1;
          state_d = ST_GUARD;
        end
`endif
      end
      ST_GUARD: begin
        // Requests made during the disable sequence are only sampled here.
        if (cnt_q == GUARD_LAST) begin
          if (bus.cfg_car_en) begin
            car_bw_d = bus.cfg_car_bw;
            state_d  = ST_ARM;
          end else begin
            state_d  = ST_IDLE;
          end
        end
      end
      default: begin
        car_en_d = 1'b0;
        state_d  = ST_IDLE;
      end
    endcase
  end

  // Shared dwell counter restarts on every state change.
  always_comb begin
    cnt_d = (state_d != state_q) ? '0 : cnt_q + 1'b1;
  end

  // State, counter and registered outputs; status flags decode the next state.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q         <= ST_IDLE;
      cnt_q           <= '0;
      car_en_q        <= 1'b0;
      car_bw_q        <= DEFAULT_BW;
      bw_active_q     <= DEFAULT_BW;
      busy_q          <= 1'b0;
      active_q        <= 1'b0;
      seq_done_q      <= 1'b0;
      ack_missing_q   <= 1'b0;
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
      flush_timeout_q <= 1'b0;
`endif
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      car_en_q      <= car_en_d;
      car_bw_q      <= car_bw_d;
      bw_active_q   <= bw_active_d;
      busy_q        <= !is_rest_state(state_d);
      active_q      <= (state_d == ST_ON);
      seq_done_q    <= (state_d != state_q) && is_rest_state(state_d);
      ack_missing_q <= bus.sticky_clr ? 1'b0 : (ack_missing_q | ack_set);
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
      flush_timeout_q <= bus.sticky_clr ? 1'b0 : (flush_timeout_q | fto_set);
`endif
    end
  end

  assign bus.car_en      = car_en_q;
  assign bus.car_bw      = car_bw_q;
  assign bus.busy        = busy_q;
  assign bus.active      = active_q;
  assign bus.bw_active   = bw_active_q;
  assign bus.seq_done    = seq_done_q;
  assign bus.ack_missing = ack_missing_q;
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
  assign bus.flush_timeout = flush_timeout_q;
`endif

endmodule

// File: tb/tb_jb_car_seq.sv
// Directed bench for jb_car_seq: expected values are queued as stimulus
// is applied and compared against the DUT at the sampling point.
// Define JB_CAR_SEQ_FLUSH_TIMEOUT_EN to also cover the flush timeout.
module tb_jb_car_seq;
  import jb_car_seq_pkg::*;

  logic clk    = 1'b0;
  logic resetn = 1'b0;
  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  typedef enum {S_CAR_EN, S_CAR_BW, S_BUSY, S_ACTIVE, S_BW_ACT, S_DONE, S_ACKM, S_FTO} sig_e;
  typedef struct {
    sig_e       s;
    logic [1:0] v;
    string      tag;
  } exp_t;
  exp_t sb[$];

  jb_car_seq_if bus();

  always #5 clk = ~clk;

  jb_car_seq #(
    .DEFAULT_BW(BW_20MHZ),
    .SETUP_CYCLES(4),
    .MIN_ON_CYCLES(32),
    .ACK_WAIT_CYCLES(16),
    .GUARD_CYCLES(8)
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    , .FLUSH_TIMEOUT_CYCLES(100)
`endif
  ) dut (
    .clk(clk),
    .resetn(resetn),
    .bus(bus)
  );

  function automatic logic [1:0] obs(sig_e s);
    case (s)
      S_CAR_EN: return {1'b0, bus.car_en};
      S_CAR_BW: return bus.car_bw;
      S_BUSY:   return {1'b0, bus.busy};
      S_ACTIVE: return {1'b0, bus.active};
      S_BW_ACT: return bus.bw_active;
      S_DONE:   return {1'b0, bus.seq_done};
      S_ACKM:   return {1'b0, bus.ack_missing};
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
      S_FTO:    return {1'b0, bus.flush_timeout};
`endif
      default:  return 2'bxx;
    endcase
  endfunction

  task automatic expect_v(sig_e s, logic [1:0] v, string tag);
    exp_t e;
    e.s = s;
    e.v = v;
    e.tag = tag;
    sb.push_back(e);
  endtask

  task automatic check();
    exp_t e;
    logic [1:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.s);
      n_vec++;
      assert (o === e.v) else begin
        n_err++;
        $error("FAIL %s: observed %0h expected %0h", e.tag, o, e.v);
      end
    end
  endtask

  task automatic tick(int unsigned n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    bus.cfg_car_en = 1'b0;
    bus.cfg_car_bw = 2'b00;
    bus.dfe_flush  = 1'b0;
    bus.sticky_clr = 1'b0;

    // Reset values while resetn is held low.
    #12;
    expect_v(S_CAR_EN, 2'd0, "rst_car_en");
    expect_v(S_CAR_BW, 2'd0, "rst_car_bw");
    expect_v(S_BW_ACT, 2'd0, "rst_bw_active");
    expect_v(S_BUSY,   2'd0, "rst_busy");
    expect_v(S_ACTIVE, 2'd0, "rst_active");
    expect_v(S_DONE,   2'd0, "rst_seq_done");
    expect_v(S_ACKM,   2'd0, "rst_ack_missing");
`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    expect_v(S_FTO,    2'd0, "rst_flush_timeout");
`endif
    check();
    @(posedge clk); #1;
    resetn = 1'b1;
    tick(2);
    expect_v(S_BUSY, 2'd0, "idle_busy");
    check();

    // Enable from IDLE with bw=01.
    bus.cfg_car_bw = 2'b01;
    bus.cfg_car_en = 1'b1;
    tick(1);
    expect_v(S_CAR_BW, 2'b01, "en_bw_latched");
    expect_v(S_CAR_EN, 2'd0,  "en_arm_car_en");
    expect_v(S_BUSY,   2'd1,  "en_arm_busy");
    check();
    tick(3);
    expect_v(S_CAR_EN, 2'd0, "en_setup_hold");
    check();
    tick(1);
    expect_v(S_CAR_EN, 2'd1,  "en_rise");
    expect_v(S_BW_ACT, 2'b01, "en_bw_active");
    expect_v(S_ACTIVE, 2'd0,  "en_onmin_active");
    check();
    tick(31);
    expect_v(S_ACTIVE, 2'd0, "en_onmin_end");
    expect_v(S_CAR_EN, 2'd1, "en_onmin_car_en");
    check();
    tick(1);
    expect_v(S_ACTIVE, 2'd1, "en_on_active");
    expect_v(S_DONE,   2'd1, "en_on_done");
    expect_v(S_BUSY,   2'd0, "en_on_busy");
    check();
    tick(1);
    expect_v(S_DONE,   2'd0, "en_done_pulse_end");
    expect_v(S_ACTIVE, 2'd1, "en_on_hold");
    check();

    // Live BW change 01 -> 10 with a long flush; cfg noise during flush.
    bus.cfg_car_bw = 2'b10;
    tick(1);
    expect_v(S_CAR_EN, 2'd0,  "bw_disable");
    expect_v(S_CAR_BW, 2'b01, "bw_hold_ackwait");
    expect_v(S_ACTIVE, 2'd0,  "bw_active_low");
    expect_v(S_BUSY,   2'd1,  "bw_busy");
    check();
    tick(3);
    bus.dfe_flush = 1'b1;
    tick(1000);
    expect_v(S_CAR_BW, 2'b01, "bw_hold_flush");
    expect_v(S_CAR_EN, 2'd0,  "bw_flush_car_en");
    check();
    bus.cfg_car_en = 1'b0;
    tick(1000);
    bus.cfg_car_en = 1'b1;
    tick(88);
    expect_v(S_CAR_BW, 2'b01, "bw_hold_flush_end");
    expect_v(S_ACKM,   2'd0,  "bw_no_ack_missing");
    check();
    bus.dfe_flush = 1'b0;
    tick(1);
    expect_v(S_CAR_BW, 2'b01, "bw_guard_start");
    expect_v(S_BUSY,   2'd1,  "bw_guard_busy");
    check();
    tick(7);
    expect_v(S_CAR_BW, 2'b01, "bw_guard_end");
    check();
    tick(1);
    expect_v(S_CAR_BW, 2'b10, "bw_relatch");
    expect_v(S_CAR_EN, 2'd0,  "bw_rearm");
    check();
    tick(3);
    expect_v(S_CAR_EN, 2'd0, "bw_rearm_hold");
    check();
    tick(1);
    expect_v(S_CAR_EN, 2'd1,  "bw_reenable");
    expect_v(S_BW_ACT, 2'b10, "bw_active_new");
    check();
    tick(32);
    expect_v(S_ACTIVE, 2'd1, "bw_on_again");
    check();

    // Disable and BW change in the same ON cycle, dfe_flush never rises.
    bus.cfg_car_en = 1'b0;
    bus.cfg_car_bw = 2'b11;
    tick(1);
    expect_v(S_CAR_EN, 2'd0,  "miss_disable");
    expect_v(S_CAR_BW, 2'b10, "miss_bw_hold");
    check();
    tick(15);
    expect_v(S_ACKM, 2'd0, "miss_not_yet");
    check();
    tick(1);
    expect_v(S_ACKM, 2'd1, "miss_set");
    expect_v(S_BUSY, 2'd1, "miss_guard_busy");
    check();
    tick(7);
    expect_v(S_BUSY, 2'd1, "miss_guard_end");
    check();
    tick(1);
    expect_v(S_BUSY,   2'd0,  "miss_idle_busy");
    expect_v(S_DONE,   2'd1,  "miss_idle_done");
    expect_v(S_CAR_BW, 2'b10, "miss_idle_bw");
    expect_v(S_ACTIVE, 2'd0,  "miss_idle_active");
    check();
    tick(4);
    expect_v(S_CAR_EN, 2'd0, "miss_stay_idle");
    expect_v(S_ACKM,   2'd1, "miss_sticky");
    check();
    bus.sticky_clr = 1'b1;
    tick(1);
    bus.sticky_clr = 1'b0;
    expect_v(S_ACKM, 2'd0, "miss_clear");
    check();

    // Short request pulse: car_en never rises.
    bus.cfg_car_bw = 2'b01;
    bus.cfg_car_en = 1'b1;
    tick(1);
    expect_v(S_BUSY,   2'd1,  "short_busy");
    expect_v(S_CAR_BW, 2'b01, "short_bw");
    expect_v(S_CAR_EN, 2'd0,  "short_car_en0");
    check();
    tick(2);
    expect_v(S_CAR_EN, 2'd0, "short_car_en1");
    check();
    bus.cfg_car_en = 1'b0;
    tick(1);
    expect_v(S_BUSY,   2'd0, "short_idle");
    expect_v(S_DONE,   2'd1, "short_done");
    expect_v(S_CAR_EN, 2'd0, "short_car_en2");
    check();
    tick(5);
    expect_v(S_CAR_EN, 2'd0, "short_car_en3");
    check();

    // sticky_clr in the same cycle ack_missing would set.
    bus.cfg_car_bw = 2'b11;
    bus.cfg_car_en = 1'b1;
    tick(5);
    expect_v(S_CAR_EN, 2'd1, "clr_on");
    check();
    tick(32);
    bus.cfg_car_en = 1'b0;
    tick(1);
    expect_v(S_CAR_EN, 2'd0, "clr_disable");
    check();
    tick(15);
    bus.sticky_clr = 1'b1;
    tick(1);
    bus.sticky_clr = 1'b0;
    expect_v(S_ACKM, 2'd0, "clr_priority");
    expect_v(S_BUSY, 2'd1, "clr_guard");
    check();
    tick(8);
    expect_v(S_BUSY, 2'd0, "clr_idle");
    expect_v(S_ACKM, 2'd0, "clr_stays0");
    check();

    // Reset in FLUSH_WAIT, then restart with dfe_flush still high.
    bus.cfg_car_bw = 2'b10;
    bus.cfg_car_en = 1'b1;
    tick(5);
    expect_v(S_BW_ACT, 2'b10, "rstf_bw_active");
    check();
    tick(32);
    bus.cfg_car_en = 1'b0;
    tick(1);
    bus.dfe_flush = 1'b1;
    tick(5);
    expect_v(S_BUSY,   2'd1,  "rstf_flush_busy");
    expect_v(S_CAR_BW, 2'b10, "rstf_flush_bw");
    check();
    #2;
    resetn = 1'b0;
    #1;
    expect_v(S_CAR_EN, 2'd0, "rstf_car_en");
    expect_v(S_CAR_BW, 2'd0, "rstf_car_bw");
    expect_v(S_BUSY,   2'd0, "rstf_busy");
    expect_v(S_BW_ACT, 2'd0, "rstf_bw_active0");
    check();
    @(posedge clk); #1;
    bus.cfg_car_bw = 2'b01;
    bus.cfg_car_en = 1'b1;
    resetn = 1'b1;
    tick(1);
    expect_v(S_CAR_BW, 2'b01, "rstf_arm_bw");
    expect_v(S_BUSY,   2'd1,  "rstf_arm_busy");
    check();
    tick(3);
    expect_v(S_CAR_EN, 2'd0, "rstf_arm_hold");
    check();
    tick(1);
    expect_v(S_CAR_EN, 2'd1, "rstf_reenable");
    check();
    bus.dfe_flush = 1'b0;
    tick(32);
    expect_v(S_ACTIVE, 2'd1, "rstf_on");
    check();

`ifdef JB_CAR_SEQ_FLUSH_TIMEOUT_EN
    // dfe_flush stuck high: timeout after 100 cycles in FLUSH_WAIT.
    bus.cfg_car_bw = 2'b11;
    tick(1);
    expect_v(S_CAR_EN, 2'd0, "fto_disable");
    check();
    bus.dfe_flush = 1'b1;
    tick(1);
    tick(99);
    expect_v(S_FTO, 2'd0, "fto_not_yet");
    check();
    tick(1);
    expect_v(S_FTO,  2'd1, "fto_set");
    expect_v(S_BUSY, 2'd1, "fto_guard");
    check();
    tick(8);
    expect_v(S_CAR_BW, 2'b11, "fto_relatch");
    expect_v(S_CAR_EN, 2'd0,  "fto_arm");
    check();
    tick(4);
    expect_v(S_CAR_EN, 2'd1,  "fto_reenable");
    expect_v(S_BW_ACT, 2'b11, "fto_bw_active");
    expect_v(S_FTO,    2'd1,  "fto_sticky");
    check();
    bus.dfe_flush = 1'b0;
    bus.sticky_clr = 1'b1;
    tick(1);
    bus.sticky_clr = 1'b0;
    expect_v(S_FTO, 2'd0, "fto_clear");
    check();
`endif

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/jb_car_seq.md
Name: jb_car_seq

Overview:
Carrier enable/bandwidth sequencer placed directly upstream of the carrier clock-enable generator. It turns register-level requests (cfg_car_en, cfg_car_bw) into a clean car_en/car_bw pair for that generator:
- car_bw is held stable before every car_en rising edge.
- Minimum on-time is enforced.
- BW changes on a live carrier run as a full disable -> flush -> guard -> re-enable cycle, closed on the generator's dfe_flush acknowledgement.

Parameters:
DEFAULT_BW, 2'b00, car_bw value at reset (b00 20MHz, b01 10MHz, b10 5MHz, b11 15MHz)
SETUP_CYCLES, 4, cycles car_bw is held stable before car_en rises (min 1)
MIN_ON_CYCLES, 32, minimum cycles car_en stays high once raised (min 1)
ACK_WAIT_CYCLES, 16, cycles allowed for dfe_flush to rise after car_en falls (min 8)
GUARD_CYCLES, 8, idle cycles after dfe_flush falls before a new enable (min 1)
FLUSH_TIMEOUT_CYCLES, 8192, max cycles in FLUSH_WAIT (used only with the optional feature)

Ports:
clk  in  1  clk_x1 domain clock
resetn  in  1  asynchronous active-low reset
cfg_car_en  in  1  requested carrier enable; level, synchronous to clk
cfg_car_bw  in  2  requested bandwidth; synchronous to clk
dfe_flush  in  1  flush-busy from the clock-enable generator
car_en  out  1  carrier enable to the generator (registered)
car_bw  out  2  bandwidth to the generator (registered)
busy  out  1  high in any state except IDLE and ON
active  out  1  high in ON
bw_active  out  2  bandwidth of the running carrier; valid while active
seq_done  out  1  one-cycle pulse on each entry to IDLE or ON from another state
ack_missing  out  1  sticky: dfe_flush did not rise within ACK_WAIT_CYCLES
sticky_clr  in  1  clears all sticky flags; takes priority over a same-cycle set

Behaviour:
- Reset values (async, resetn=0): state IDLE; car_en=0; car_bw=DEFAULT_BW; bw_active=DEFAULT_BW; busy=0; active=0; seq_done=0; all sticky flags 0; counter 0.
- All outputs are registered.
- One shared 16-bit counter, cleared on every state change.

States and transitions:
- IDLE: if cfg_car_en=1, latch car_bw<=cfg_car_bw and go to ARM.
- ARM: hold car_bw. After SETUP_CYCLES cycles, set car_en<=1, bw_active<=car_bw, go to ON_MIN.
  - If cfg_car_en drops during ARM, go to IDLE; car_en never rises.
- ON_MIN: stay MIN_ON_CYCLES cycles, then go to ON. Requests are ignored here; the check is made at ON.
- ON: stay while cfg_car_en=1 and cfg_car_bw==car_bw. Otherwise set car_en<=0 and go to ACK_WAIT.
- ACK_WAIT: on dfe_flush=1 go to FLUSH_WAIT. After ACK_WAIT_CYCLES without it, set ack_missing and go to GUARD.
- FLUSH_WAIT: on dfe_flush=0 go to GUARD.
- GUARD: after GUARD_CYCLES cycles:
  - if cfg_car_en=1: latch car_bw<=cfg_car_bw, go to ARM;
  - else go to IDLE.

Latency and boundary conditions:
- Latency, IDLE request to car_en=1: SETUP_CYCLES+1 clk.
- car_bw changes only in IDLE and GUARD (latch), never while car_en=1 or in ACK_WAIT/FLUSH_WAIT.
- BW change and disable on the same ON cycle: one disable sequence, ending in IDLE.
- cfg toggles during ACK_WAIT/FLUSH_WAIT/GUARD: ignored until the GUARD exit decision.
- dfe_flush=1 seen in IDLE/ARM: ignored. The generator qualifies its enable with the flush, so ARM still completes.
- Reset mid-operation: car_en drops asynchronously; the downstream generator runs its own flush.

Optional Feature:
Macro JB_CAR_SEQ_FLUSH_TIMEOUT_EN.
- Defined: adds output flush_timeout (1b, sticky, cleared by sticky_clr). If FLUSH_WAIT lasts FLUSH_TIMEOUT_CYCLES, set flush_timeout and force GUARD.
- Undefined: no port, no timeout; FLUSH_WAIT waits indefinitely for dfe_flush=0.

Decomposition:
- Shared package jb_common (existing): BW_20MHZ/BW_10MHZ/BW_5MHZ/BW_15MHZ constants and a bw_t 2-bit typedef.
- Local enum for the state encoding (IDLE, ARM, ON_MIN, ON, ACK_WAIT, FLUSH_WAIT, GUARD).
- Single module, no sub-module. The counter is inline.

Test Plan:
- Enable from IDLE: cfg_car_bw=01, cfg_car_en 0->1 at cycle 0 -> car_bw=01 from cycle 1; car_en=1 at cycle 5 (SETUP=4); active=1 after 32 more cycles; seq_done pulses once on entry to ON.
- BW change live: in ON, cfg_car_bw 00->10, model dfe_flush rising 4 cycles after car_en falls and high for 2048+40 cycles -> car_en=0, car_bw stays 00 through the flush; after GUARD(8), car_bw=10; car_en=1 SETUP_CYCLES later; bw_active=10.
- Short pulse: cfg_car_en high 3 cycles only -> car_en never rises, state returns to IDLE, busy=0 after 4 cycles.
- Missing ack: dfe_flush held 0 after disable -> ack_missing=1 exactly 16 cycles after car_en falls, GUARD, then IDLE. sticky_clr and an ack_missing set in the same cycle -> flag stays 0.
- Reset mid-flush: resetn=0 during FLUSH_WAIT -> car_en=0, car_bw=DEFAULT_BW, busy=0 immediately. After release with cfg_car_en=1 -> normal ARM sequence.
- With JB_CAR_SEQ_FLUSH_TIMEOUT_EN and FLUSH_TIMEOUT_CYCLES=100: dfe_flush stuck at 1 -> flush_timeout=1 at cycle 100 of FLUSH_WAIT, GUARD, then re-enable if cfg_car_en=1.
